// File: rtl/result_serialize_pkg.sv
`default_nettype none
// ============================================================================
// Module      : result_serialize_pkg
// Description : Shared constants and types for the result serializer: config
//               register addresses, frame length width and the FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package result_serialize_pkg;

  // Config register addresses; the store address sits next to the layers one.
  localparam int CFG_LAYERS  = 1;
  localparam int CFG_STORE   = 2;

  // Frame length register width (words per frame minus one).
  localparam int FRAME_LEN_W = 16;

  // EMPTY: no word held. SEND: a word is held and being emitted beat by beat.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } state_e;

endpackage : result_serialize_pkg
`default_nettype wire

// File: rtl/result_serialize_fv.sv
`default_nettype none
// ============================================================================
// Module      : result_serialize_fv
// Description : Handshake property checker for result_serialize. Observes the
//               interface signals and asserts the valid/ready rules.
// Revision    : 1.0 - initial release
// ============================================================================
module result_serialize_fv #(
  parameter int LW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          result_val,
  input  logic          result_rdy,
  input  logic [LW-1:0] str_bus,
  input  logic          str_last,
  input  logic          str_val,
  input  logic          str_rdy
);

  logic          past_ok_q;
  logic          stall_q;
  logic          str_xfer_q;
  logic          res_xfer_q;
  logic          str_val_q;
  logic          result_rdy_q;
  logic [LW-1:0] str_bus_q;
  logic          str_last_q;

  // Capture last cycle's interface state; past_ok_q marks a cycle spent out
  // of reset so checks never compare across a reset boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      past_ok_q <= 1'b0;
    end else begin
      past_ok_q <= 1'b1;
    end
    stall_q      <= str_val && !str_rdy;
    str_xfer_q   <= str_val && str_rdy;
    res_xfer_q   <= result_val && result_rdy;
    str_val_q    <= str_val;
    result_rdy_q <= result_rdy;
    str_bus_q    <= str_bus;
    str_last_q   <= str_last;
  end

  // Handshake properties, checked between two consecutive out-of-reset cycles.
  always_ff @(posedge clk) begin
    if (!rst && past_ok_q) begin
      if (stall_q) begin
        assert (str_bus == str_bus_q && str_last == str_last_q);
      end
      if (str_val_q && !str_val) begin
        assert (str_xfer_q);
      end
      if (result_rdy_q && !result_rdy) begin
        assert (res_xfer_q);
      end
    end
  end

endmodule : result_serialize_fv
`default_nettype wire

// File: rtl/result_serialize.sv
`default_nettype none
// ============================================================================
// Module      : result_serialize
// Description : Accepts one full-depth result word per valid/ready transfer and
//               emits it as DEPTH_NB/GROUP_NB narrower beats, counting words per
//               frame and flagging the final beat of each frame with str_last.
// Revision    : 1.0 - initial release
// ============================================================================
module result_serialize
  import result_serialize_pkg::*;
#(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int DEPTH_NB   = 16,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic [IMG_WIDTH*DEPTH_NB-1:0] result_bus,
  input  logic                          result_val,
  output logic                          result_rdy,
  output logic [GROUP_NB*IMG_WIDTH-1:0] str_bus,
  output logic                          str_last,
  output logic                          str_val,
  input  logic                          str_rdy,
  output logic                          busy
);

  localparam int BEATS = DEPTH_NB / GROUP_NB;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = GROUP_NB * IMG_WIDTH;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  state_e                        state_q, state_d;
  logic [IMG_WIDTH*DEPTH_NB-1:0] hold_q, hold_d;
  logic [BW-1:0]                 beat_q, beat_d;
  logic [FRAME_LEN_W-1:0]        word_cnt_q, word_cnt_d;
  logic [FRAME_LEN_W-1:0]        frame_len_q, frame_len_d;
  logic [FRAME_LEN_W-1:0]        frame_len_nxt_q, frame_len_nxt_d;

  logic full;
  logic beat_last;
  logic frame_last;
  logic str_xfer;
  logic res_xfer;
  logic cfg_hit;
  logic unused_cfg_bits;

  // Only the low 16 config bits carry the frame length.
  assign unused_cfg_bits = ^cfg_data;

  assign full       = (state_q == ST_SEND);
  assign beat_last  = (beat_q == LAST_BEAT);
  assign frame_last = (word_cnt_q == frame_len_q);
  assign cfg_hit    = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_STORE));

  // Outputs are forced quiet while reset is high, since the registers only
  // clear on the following edge.
  assign result_rdy = ~rst && (~full || (str_rdy && beat_last));
  assign str_val    = ~rst && full;
  assign str_last   = ~rst && full && beat_last && frame_last;
  assign busy       = ~rst && ((word_cnt_q != '0) || full);
  assign str_bus    = rst ? '0 : hold_q[int'(beat_q)*LW +: LW];

  assign str_xfer   = str_val && str_rdy;
  assign res_xfer   = result_val && result_rdy;

  // Next-state logic: config staging, frame-boundary length load, word hold
  // and beat/word counting.
  always_comb begin
    state_d         = state_q;
    hold_d          = hold_q;
    beat_d          = beat_q;
    word_cnt_d      = word_cnt_q;
    frame_len_d     = frame_len_q;
    frame_len_nxt_d = frame_len_nxt_q;

    if (cfg_hit) begin
      frame_len_nxt_d = cfg_data[FRAME_LEN_W-1:0];
    end

    // Frame boundary: the staged value (before any same-cycle write) becomes
    // active, so a mid-frame write only affects the following frame.
    if (!full && (word_cnt_q == '0)) begin
      frame_len_d = frame_len_nxt_q;
    end

    case (state_q)
      ST_EMPTY: begin
        if (res_xfer) begin
          state_d = ST_SEND;
          hold_d  = result_bus;
          beat_d  = '0;
        end
      end
      ST_SEND: begin
        if (str_xfer) begin
          if (beat_last) begin
            word_cnt_d = frame_last ? '0 : word_cnt_q + FRAME_LEN_W'(1);
            beat_d     = '0;
            // A word offered on the final beat is taken without a bubble.
            if (res_xfer) begin
              hold_d = result_bus;
            end else begin
              state_d = ST_EMPTY;
            end
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State register with synchronous reset; reset drops any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_EMPTY;
      hold_q          <= '0;
      beat_q          <= '0;
      word_cnt_q      <= '0;
      frame_len_q     <= '0;
      frame_len_nxt_q <= '0;
    end else begin
      state_q         <= state_d;
      hold_q          <= hold_d;
      beat_q          <= beat_d;
      word_cnt_q      <= word_cnt_d;
      frame_len_q     <= frame_len_d;
      frame_len_nxt_q <= frame_len_nxt_d;
    end
  end

endmodule : result_serialize
`default_nettype wire

// File: tb/tb_result_serialize.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_serialize
// Description : Self-checking bench for result_serialize: a cycle table for
//               single/multi-word frames and config handling, plus sequences
//               for stalls, mid-frame reconfiguration and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_serialize;
  import result_serialize_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  cfg_data;
  logic [4:0]   cfg_addr;
  logic         cfg_valid;
  logic [255:0] result_bus;
  logic         result_val;
  logic         result_rdy;
  logic [63:0]  str_bus;
  logic         str_last;
  logic         str_val;
  logic         str_rdy;
  logic         busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  result_serialize dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_data   (cfg_data),
    .cfg_addr   (cfg_addr),
    .cfg_valid  (cfg_valid),
    .result_bus (result_bus),
    .result_val (result_val),
    .result_rdy (result_rdy),
    .str_bus    (str_bus),
    .str_last   (str_last),
    .str_val    (str_val),
    .str_rdy    (str_rdy),
    .busy       (busy)
  );

  result_serialize_fv #(.LW(64)) u_fv (
    .clk        (clk),
    .rst        (rst),
    .result_val (result_val),
    .result_rdy (result_rdy),
    .str_bus    (str_bus),
    .str_last   (str_last),
    .str_val    (str_val),
    .str_rdy    (str_rdy)
  );

  typedef struct packed {
    logic        cv;
    logic [4:0]  ca;
    logic [15:0] cd;
    logic        rv;
    logic [15:0] base;
    logic        sr;
    logic        e_val;
    logic        e_last;
    logic [15:0] e_lane0;
    logic        e_rrdy;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  // Word whose lane i holds base+i.
  function automatic logic [255:0] mkword(input logic [15:0] b);
    logic [255:0] w;
    for (int i = 0; i < 16; i++) w[i*16 +: 16] = b + 16'(i);
    return w;
  endfunction

  // Beat holding four consecutive lanes starting at l0.
  function automatic logic [63:0] mkbeat(input logic [15:0] l0);
    logic [63:0] w;
    for (int i = 0; i < 4; i++) w[i*16 +: 16] = l0 + 16'(i);
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic setin(input logic r, input logic cv, input logic [4:0] ca,
                       input logic [15:0] cd, input logic rv,
                       input logic [15:0] b, input logic sr);
    rst        = r;
    cfg_valid  = cv;
    cfg_addr   = ca;
    cfg_data   = {16'hABCD, cd};
    result_val = rv;
    result_bus = mkword(b);
    str_rdy    = sr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input logic cv, input logic [4:0] ca, input logic [15:0] cd,
                      input logic rv, input logic [15:0] b, input logic sr,
                      input logic ev, input logic el, input logic [15:0] l0,
                      input logic err, input logic ebz);
    vec_t v;
    v = '{cv, ca, cd, rv, b, sr, ev, el, l0, err, ebz};
    vecs.push_back(v);
  endtask

  // Accept one word, then expect its four beats; last only on beat 3 if asked.
  task automatic send_word(input string tag, input logic [15:0] b, input logic exp_last);
    setin(0, 0, 0, 0, 1, b, 1);
    @(negedge clk);
    chk({tag, ".accept_rdy"}, 64'(result_rdy), 64'd1);
    chk({tag, ".accept_val"}, 64'(str_val), 64'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      setin(0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk($sformatf("%s.b%0d.bus", tag, k), str_bus, mkbeat(b + 16'(4*k)));
      chk($sformatf("%s.b%0d.last", tag, k), 64'(str_last), 64'(exp_last && k == 3));
      chk($sformatf("%s.b%0d.rdy", tag, k), 64'(result_rdy), 64'(k == 3));
      step();
    end
  endtask

  initial begin
    logic [3:0] pat;
    int         eb;
    pat = 4'b1001;

    // Reset: every output quiet, even with a word offered.
    setin(1, 0, 0, 0, 1, 16'h55, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst.val", 64'(str_val), 64'd0);
      chk("rst.last", 64'(str_last), 64'd0);
      chk("rst.rdy", 64'(result_rdy), 64'd0);
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.bus", str_bus, 64'd0);
      step();
    end

    // c0..c5: 1-word frame, write to a foreign address alongside.
    addv(1, 5'd3, 16'd5, 1, 16'd0, 1,  0, 0, 16'd0,  1, 0);
    addv(0, 0, 0,        0, 0,     1,  1, 0, 16'd0,  0, 1);
    addv(0, 0, 0,        0, 0,     1,  1, 0, 16'd4,  0, 1);
    addv(0, 0, 0,        0, 0,     1,  1, 0, 16'd8,  0, 1);
    addv(0, 0, 0,        0, 0,     1,  1, 1, 16'd12, 1, 1);
    addv(0, 0, 0,        0, 0,     1,  0, 0, 16'd0,  1, 0);
    // c6..c10: after a frame boundary, length must still be 1 word.
    addv(0, 0, 0,        1, 16'd16, 1, 0, 0, 16'd0,  1, 0);
    addv(0, 0, 0,        0, 0,     1,  1, 0, 16'd16, 0, 1);
    addv(0, 0, 0,        0, 0,     1,  1, 0, 16'd20, 0, 1);
    addv(0, 0, 0,        0, 0,     1,  1, 0, 16'd24, 0, 1);
    addv(0, 0, 0,        0, 0,     1,  1, 1, 16'd28, 1, 1);
    // c11: configure 3-word frames; c12..c25: three words back-to-back.
    addv(1, 5'(CFG_STORE), 16'd2, 0, 0, 1, 0, 0, 16'd0, 1, 0);
    addv(0, 0, 0,        1, 16'd32, 1, 0, 0, 16'd0,  1, 0);
    addv(0, 0, 0,        1, 16'd48, 1, 1, 0, 16'd32, 0, 1);
    addv(0, 0, 0,        1, 16'd48, 1, 1, 0, 16'd36, 0, 1);
    addv(0, 0, 0,        1, 16'd48, 1, 1, 0, 16'd40, 0, 1);
    addv(0, 0, 0,        1, 16'd48, 1, 1, 0, 16'd44, 1, 1);
    addv(0, 0, 0,        1, 16'd64, 1, 1, 0, 16'd48, 0, 1);
    addv(0, 0, 0,        1, 16'd64, 1, 1, 0, 16'd52, 0, 1);
    addv(0, 0, 0,        1, 16'd64, 1, 1, 0, 16'd56, 0, 1);
    addv(0, 0, 0,        1, 16'd64, 1, 1, 0, 16'd60, 1, 1);
    addv(0, 0, 0,        0, 0,     1,  1, 0, 16'd64, 0, 1);
    addv(0, 0, 0,        0, 0,     1,  1, 0, 16'd68, 0, 1);
    addv(0, 0, 0,        0, 0,     1,  1, 0, 16'd72, 0, 1);
    addv(0, 0, 0,        0, 0,     1,  1, 1, 16'd76, 1, 1);
    addv(0, 0, 0,        0, 0,     1,  0, 0, 16'd0,  1, 0);

    foreach (vecs[i]) begin
      setin(0, vecs[i].cv, vecs[i].ca, vecs[i].cd, vecs[i].rv, vecs[i].base, vecs[i].sr);
      @(negedge clk);
      chk($sformatf("vec%0d.val", i), 64'(str_val), 64'(vecs[i].e_val));
      chk($sformatf("vec%0d.last", i), 64'(str_last), 64'(vecs[i].e_last));
      chk($sformatf("vec%0d.rdy", i), 64'(result_rdy), 64'(vecs[i].e_rrdy));
      chk($sformatf("vec%0d.busy", i), 64'(busy), 64'(vecs[i].e_busy));
      if (vecs[i].e_val) chk($sformatf("vec%0d.bus", i), str_bus, mkbeat(vecs[i].e_lane0));
      step();
    end

    // Stalled word 1 of a 3-word frame; CFG_STORE=0 written mid-frame.
    setin(0, 0, 0, 0, 1, 16'd80, 1);
    @(negedge clk);
    chk("stall.accept_rdy", 64'(result_rdy), 64'd1);
    step();
    eb = 0;
    for (int k = 0; k < 8; k++) begin
      setin(0, (k == 1), 5'(CFG_STORE), 16'd0, 0, 0, pat[3 - (k % 4)]);
      @(negedge clk);
      chk($sformatf("stall%0d.val", k), 64'(str_val), 64'd1);
      chk($sformatf("stall%0d.bus", k), str_bus, mkbeat(16'd80 + 16'(4*eb)));
      chk($sformatf("stall%0d.last", k), 64'(str_last), 64'd0);
      chk($sformatf("stall%0d.rdy", k), 64'(result_rdy), 64'(str_rdy && eb == 3));
      if (str_rdy) eb++;
      step();
    end
    send_word("midcfg.w2", 16'd96, 0);
    send_word("midcfg.w3", 16'd112, 1);
    send_word("newlen.w1", 16'd128, 1);

    // Reset at beat 2 of word 1 of a 3-word frame.
    setin(0, 1, 5'(CFG_STORE), 16'd2, 0, 0, 1);
    step();
    setin(0, 0, 0, 0, 0, 0, 1);
    step();
    setin(0, 0, 0, 0, 1, 16'd144, 1);
    step();
    for (int k = 0; k < 2; k++) begin
      setin(0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk($sformatf("prerst.b%0d.bus", k), str_bus, mkbeat(16'd144 + 16'(4*k)));
      step();
    end
    setin(1, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("midrst.val", 64'(str_val), 64'd0);
    chk("midrst.last", 64'(str_last), 64'd0);
    chk("midrst.rdy", 64'(result_rdy), 64'd0);
    chk("midrst.bus", str_bus, 64'd0);
    step();
    setin(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("postrst.val", 64'(str_val), 64'd0);
    chk("postrst.busy", 64'(busy), 64'd0);
    chk("postrst.rdy", 64'(result_rdy), 64'd1);
    step();
    send_word("postrst.w1", 16'd160, 1);
    setin(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("end.busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_result_serialize
`default_nettype wire

// File: doc/result_serialize.md
# result_serialize

Downstream neighbour of `layers`: accepts one full-depth result word (`DEPTH_NB` lanes of `IMG_WIDTH` bits) per valid/ready transfer and emits it as `DEPTH_NB/GROUP_NB` narrower beats of `GROUP_NB` lanes each, toward the store path. It counts result words per frame against a configured length and marks the final beat of each frame with `str_last`. Handshakes on both sides follow the codebase's valid/ready rules, so the block can be formally checked with the same interface properties as `layers`.

## Interface
- `CFG_DWIDTH`, 32, config data width
- `CFG_AWIDTH`, 5, config address width
- `DEPTH_NB`, 16, lanes per result word; must be a multiple of `GROUP_NB`
- `GROUP_NB`, 4, lanes per output beat
- `IMG_WIDTH`, 16, bits per lane
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `cfg_data`  in  `CFG_DWIDTH`  config payload
- `cfg_addr`  in  `CFG_AWIDTH`  config register select
- `cfg_valid`  in  1  config write strobe
- `result_bus`  in  `IMG_WIDTH*DEPTH_NB`  result word from `layers`; lane 0 = bits [IMG_WIDTH-1:0]
- `result_val`  in  1  result word valid
- `result_rdy`  out  1  block can accept a result word
- `str_bus`  out  `GROUP_NB*IMG_WIDTH`  output beat
- `str_last`  out  1  last beat of the frame
- `str_val`  out  1  beat valid
- `str_rdy`  in  1  downstream accepts beat
- `busy`  out  1  a frame is in progress (`word_cnt` ≠ 0 or a word is held)

## Operation
- `BEATS = DEPTH_NB/GROUP_NB`. Internal state: holding register `hold` (full word), flag `full`, beat counter `beat` (0..BEATS-1), word counter `word_cnt`, active length `frame_len`, staged length `frame_len_nxt`.
- Config: when `cfg_valid` and `cfg_addr == CFG_STORE`, `frame_len_nxt <= cfg_data[15:0]`. This value is encoded as (words per frame − 1). Bits above 15 are ignored. Writes to other addresses are ignored.
- `frame_len <= frame_len_nxt` only when `word_cnt == 0` and the block is not `full`, i.e. at a frame boundary. A write made mid-frame takes effect on the next frame.
- States: EMPTY (`full=0`) and SEND (`full=1`).
  - EMPTY → SEND on a `result_val && result_rdy` transfer: `hold <= result_bus`, `beat <= 0`.
  - In SEND, each `str_val && str_rdy` transfer increments `beat`.
  - On the transfer with `beat == BEATS-1`, the word is complete. If `result_val` is high in that same cycle, reload `hold` and stay in SEND; otherwise go to EMPTY.
- `str_bus` = lanes [`beat*GROUP_NB` .. `beat*GROUP_NB+GROUP_NB-1`] of `hold`, lowest lanes first.
- `str_val = full`.
- `str_last = full && beat == BEATS-1 && word_cnt == frame_len`.
- `word_cnt` increments on each completed word. After the `str_last` word completes it wraps to 0.
- `result_rdy = ~rst && (~full || (str_rdy && beat == BEATS-1))`. This is the only combinational input→output path (`str_rdy`→`result_rdy`).
- When `BEATS == 1` the block is a registered pass-through stage with frame counting.

## Timing
- Reset values: `full=0`, `beat=0`, `word_cnt=0`, `frame_len=frame_len_nxt=0` (1-word frames), `hold=0`.
- Output values while `rst` is high: `str_val=0`, `str_last=0`, `busy=0`, `result_rdy=0`, `str_bus=0`.
- Reset mid-frame discards the held word and all counters in the same edge. `result_rdy` rises in the first cycle after `rst` falls.
- Latency: a result accepted at edge t produces its first beat with `str_val` high in cycle t+1.
- Throughput: with `str_rdy` and `result_val` held high, one beat per cycle and no bubble between words. A sustained input rate of 1 word per `BEATS` cycles is met.
- Handshake rules (all must hold):
  - `str_bus` and `str_last` are stable while `str_val && ~str_rdy`.
  - `str_val` falls only in the cycle after a transfer.
  - `result_rdy` falls only in the cycle after a `result_val` transfer.
- A config write in the same cycle as the frame-boundary load: the new value is written into `frame_len_nxt`, and the old `frame_len_nxt` is loaded into `frame_len`.

## Structure
- Add the address constant `CFG_STORE` to the shared `cfg_parameters.vh`, next to `CFG_LAYERS`. No other shared constants are needed.
- `BEATS` and the beat counter width (`clog2(BEATS)`, minimum 1) are local parameters.
- Single module, no sub-module. The beat lane mux is an indexed part-select of `hold`.
- Provide a formal wrapper `result_serialize_fv` carrying the handshake properties above.

## Test plan
- Default config, `DEPTH_NB=16`, `GROUP_NB=4`; one word with lanes 0..15 = 0x0000..0x000F; `str_rdy=1` → 4 beats {0..3}, {4..7}, {8..11}, {12..15}; `str_last` on beat 4.
- Configure `CFG_STORE` = 2; send 3 words back-to-back with `result_val` and `str_rdy` high → 12 consecutive beats, no gaps; `str_last` only on beat 12; `busy` low afterwards.
- `str_rdy` toggled 1,0,0,1 repeatedly during a word → `str_bus` and `str_last` hold while stalled; `result_rdy` stays 0 until the final beat is accepted.
- Write `CFG_STORE` = 0 in the middle of a 3-word frame → that frame still ends after word 3; the next frame ends after 1 word.
- Assert `rst` at beat 2 of word 1 → next cycle `str_val=0`, `word_cnt=0`; a new word after reset starts at beat 0 with frame length 1.
- Write `cfg_addr` ≠ `CFG_STORE` with `cfg_data=5` → frame length unchanged.
